// File: rtl/binary_div_12_6_uni_if.sv
// rtl/binary_div_12_6_uni_if.sv - operand/result bundle for the 12/6 restoring divider
interface binary_div_12_6_uni_if;
    logic [11:0] P;
    logic [5:0]  B;
    logic        start;
    logic [11:0] Q;
    logic [5:0]  R;
    logic        busy;
    logic        done;
    logic        dz;

    modport master (
        output P, B, start,
        input  Q, R, busy, done, dz
    );

    modport slave (
        input  P, B, start,
        output Q, R, busy, done, dz
    );
endinterface

// File: rtl/binary_div_12_6_uni.sv
// rtl/binary_div_12_6_uni.sv - 12-bit by 6-bit unsigned restoring divider, one quotient bit per cycle
module binary_div_12_6_uni (
    input  logic                  clk,
    input  logic                  rst,
    binary_div_12_6_uni_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] dvd, dvd_nxt;
    logic [5:0]  dvs, dvs_nxt;
    logic [6:0]  rem, rem_nxt;
    logic [11:0] quo, quo_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [11:0] q_nxt;
    logic [5:0]  r_nxt;
    logic        done_nxt;
    logic        dz_nxt;

    // Seven bits so the shifted-in dividend bit never overflows before the compare.
    logic [6:0]  trial;
    logic [6:0]  diff;
    logic        ge;

    assign trial    = {rem[5:0], dvd[11]};
    assign ge       = (trial >= {1'b0, dvs});
    assign diff     = trial - {1'b0, dvs};
    assign bus.busy = (state == RUN);

    always_comb begin
        state_nxt = state;
        dvd_nxt   = dvd;
        dvs_nxt   = dvs;
        rem_nxt   = rem;
        quo_nxt   = quo;
        cnt_nxt   = cnt;
        q_nxt     = bus.Q;
        r_nxt     = bus.R;
        dz_nxt    = bus.dz;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.B != 6'd0) begin
                        dvd_nxt   = bus.P;
                        dvs_nxt   = bus.B;
                        rem_nxt   = 7'd0;
                        quo_nxt   = 12'd0;
                        cnt_nxt   = 4'd11;
                        state_nxt = RUN;
                    end else begin
                        q_nxt    = 12'hFFF;
                        r_nxt    = 6'd0;
                        dz_nxt   = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_nxt = ge ? diff : trial;
                quo_nxt = {quo[10:0], ge};
                dvd_nxt = {dvd[10:0], 1'b0};
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd0) begin
                    q_nxt     = {quo[10:0], ge};
                    r_nxt     = rem_nxt[5:0];
                    dz_nxt    = 1'b0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dvd      <= 12'd0;
            dvs      <= 6'd0;
            rem      <= 7'd0;
            quo      <= 12'd0;
            cnt      <= 4'd0;
            bus.Q    <= 12'd0;
            bus.R    <= 6'd0;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dvd      <= dvd_nxt;
            dvs      <= dvs_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            cnt      <= cnt_nxt;
            bus.Q    <= q_nxt;
            bus.R    <= r_nxt;
            bus.done <= done_nxt;
            bus.dz   <= dz_nxt;
        end
    end

endmodule

// File: tb/tb_binary_div_12_6_uni.sv
// tb/tb_binary_div_12_6_uni.sv - directed and sweep checks for binary_div_12_6_uni
module tb_binary_div_12_6_uni;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    binary_div_12_6_uni_if bus ();

    binary_div_12_6_uni dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // lat counts edges after the edge that samples start (0 = that same edge); -1 means timeout.
    task automatic do_div(input logic [11:0] p, input logic [5:0] b,
                          output logic [11:0] q, output logic [5:0] r, output logic z,
                          output int lat, output logic busy_seen);
        @(negedge clk);
        bus.P = p;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        busy_seen = bus.busy;
        if (bus.done) lat = 0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done) lat = i;
        end
        q = bus.Q;
        r = bus.R;
        z = bus.dz;
    endtask

    task automatic test_reset();
        bus.P = 12'd100;
        bus.B = 6'd7;
        bus.start = 1'b1;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.Q !== 12'd0 || bus.R !== 6'd0 || bus.done !== 1'b0 || bus.dz !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_outputs got Q=%0d R=%0d done=%b dz=%b busy=%b want all 0", bus.Q, bus.R, bus.done, bus.dz, bus.busy);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL start_during_reset got busy=%b done=%b want 0 0", bus.busy, bus.done);
        else pass_cnt++;
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [11:0] q; logic [5:0] r; logic z; int lat; logic bs;
        do_div(12'd100, 6'd7, q, r, z, lat, bs);
        total_cnt++;
        if (q !== 12'd14 || r !== 6'd2 || z !== 1'b0)
            $display("FAIL div_100_7 got Q=%0d R=%0d dz=%b want Q=14 R=2 dz=0", q, r, z);
        else pass_cnt++;
        total_cnt++;
        if (lat != 12) $display("FAIL latency_100_7 got %0d want 12", lat);
        else pass_cnt++;
        total_cnt++;
        if (bs !== 1'b1) $display("FAIL busy_100_7 got %b want 1", bs);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Q !== 12'd14 || bus.R !== 6'd2)
            $display("FAIL after_done got done=%b busy=%b Q=%0d R=%0d want 0 0 14 2", bus.done, bus.busy, bus.Q, bus.R);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        logic [11:0] pv [4] = '{12'd4095, 12'd4095, 12'd0, 12'd62};
        logic [5:0]  bv [4] = '{6'd63, 6'd1, 6'd5, 6'd63};
        logic [11:0] qv [4] = '{12'd65, 12'd4095, 12'd0, 12'd0};
        logic [5:0]  rv [4] = '{6'd0, 6'd0, 6'd0, 6'd62};
        logic [11:0] q; logic [5:0] r; logic z; int lat; logic bs;
        for (int i = 0; i < 4; i++) begin
            do_div(pv[i], bv[i], q, r, z, lat, bs);
            total_cnt++;
            if (q !== qv[i] || r !== rv[i] || z !== 1'b0 || lat != 12)
                $display("FAIL boundary_%0d_%0d got Q=%0d R=%0d dz=%b lat=%0d want Q=%0d R=%0d dz=0 lat=12",
                         pv[i], bv[i], q, r, z, lat, qv[i], rv[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        logic [11:0] q; logic [5:0] r; logic z; int lat; logic bs;
        do_div(12'd1234, 6'd0, q, r, z, lat, bs);
        total_cnt++;
        if (q !== 12'hFFF || r !== 6'd0 || z !== 1'b1)
            $display("FAIL div_zero got Q=%0d R=%0d dz=%b want Q=4095 R=0 dz=1", q, r, z);
        else pass_cnt++;
        total_cnt++;
        if (lat != 0 || bs !== 1'b0)
            $display("FAIL div_zero_timing got lat=%0d busy=%b want lat=0 busy=0", lat, bs);
        else pass_cnt++;
        do_div(12'd10, 6'd3, q, r, z, lat, bs);
        total_cnt++;
        if (q !== 12'd3 || r !== 6'd1 || z !== 1'b0 || lat != 12)
            $display("FAIL after_div_zero got Q=%0d R=%0d dz=%b lat=%0d want Q=3 R=1 dz=0 lat=12", q, r, z, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] q; logic [5:0] r; logic z; int lat; logic bs;
        do_div(12'd1000, 6'd33, q, r, z, lat, bs);
        do_div(12'd2047, 6'd17, q, r, z, lat, bs);
        total_cnt++;
        if (q !== 12'd120 || r !== 6'd7 || lat != 12)
            $display("FAIL back_to_back got Q=%0d R=%0d lat=%0d want Q=120 R=7 lat=12", q, r, lat);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        logic [11:0] q = '0;
        logic [5:0]  r = '0;
        @(negedge clk);
        bus.P = 12'd200;
        bus.B = 6'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                q = bus.Q;
                r = bus.R;
            end
            if (i == 5) begin
                bus.P = 12'd7;
                bus.B = 6'd2;
                bus.start = 1'b1;
            end
            if (i == 6) bus.start = 1'b0;
        end
        total_cnt++;
        if (ndone != 1) $display("FAIL start_ignored_pulses got %0d want 1", ndone);
        else pass_cnt++;
        total_cnt++;
        if (q !== 12'd22 || r !== 6'd2)
            $display("FAIL start_ignored_result got Q=%0d R=%0d want Q=22 R=2", q, r);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        logic [11:0] q; logic [5:0] r; logic z; int lat; logic bs;
        @(negedge clk);
        bus.P = 12'd100;
        bus.B = 6'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.Q !== 12'd0 || bus.R !== 6'd0 || bus.done !== 1'b0 || bus.dz !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL reset_mid_run got Q=%0d R=%0d done=%b dz=%b busy=%b want all 0", bus.Q, bus.R, bus.done, bus.dz, bus.busy);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        total_cnt++;
        if (ndone != 0) $display("FAIL reset_no_done got %0d active cycles want 0", ndone);
        else pass_cnt++;
        do_div(12'd36, 6'd6, q, r, z, lat, bs);
        total_cnt++;
        if (q !== 12'd6 || r !== 6'd0 || lat != 12)
            $display("FAIL after_reset got Q=%0d R=%0d lat=%0d want Q=6 R=0 lat=12", q, r, lat);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [11:0] q; logic [5:0] r; logic z; int lat; logic bs;
        int p, b;
        for (int a = 1; a <= 63; a++) begin
            for (int d = 1; d <= 63; d++) begin
                do_div(12'(a * d), 6'(d), q, r, z, lat, bs);
                total_cnt++;
                if (q !== 12'(a) || r !== 6'd0 || lat != 12)
                    $display("FAIL sweep_%0d_%0d got Q=%0d R=%0d lat=%0d want Q=%0d R=0", a * d, d, q, r, lat, a);
                else pass_cnt++;
            end
        end
        for (int i = 0; i < 200; i++) begin
            p = int'($urandom_range(0, 4095));
            b = int'($urandom_range(1, 63));
            do_div(12'(p), 6'(b), q, r, z, lat, bs);
            total_cnt++;
            if (int'(q) * b + int'(r) != p || int'(r) >= b || z !== 1'b0)
                $display("FAIL random_%0d_%0d got Q=%0d R=%0d dz=%b", p, b, q, r, z);
            else pass_cnt++;
        end
    endtask

    initial begin
        bus.P = 12'd0;
        bus.B = 6'd0;
        bus.start = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
